dfd_mux_sel_sequencer: RTL

- Time-multiplexes the debug bus mux select.
- Holds a small table of mux-select words, each with a dwell time, and steps the mux select through them automatically. One trace capture therefore covers several signal groups without software reprogramming between them.
- Sits between the DFD CSR block and the debug bus mux select input.
- Its output also drives a blanking/valid qualifier to the trace/CLA logic while the 3-stage mux pipeline refills after a select change.

---
 rtl/dfd_tt_dbm_pkg.sv | 21 ++
 rtl/dfd_mux_seq_dwell_cnt.sv | 29 ++
 rtl/dfd_mux_sel_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dfd_tt_dbm_pkg.sv
// Shared debug-bus-mux types: sequencer state encoding, select-table entry layout
// and the mux pipeline depth that sets how long a new select needs to settle.
package dfd_tt_dbm_pkg;

   localparam int DBG_MUX_PIPE_DEPTH  = 3;
   localparam int MUX_SEQ_SEL_WIDTH   = 32;
   localparam int MUX_SEQ_DWELL_WIDTH = 16;

   typedef enum logic [1:0] {
      MUX_SEQ_IDLE = 2'd0,
      MUX_SEQ_ARM  = 2'd1,
      MUX_SEQ_RUN  = 2'd2,
      MUX_SEQ_DONE = 2'd3
   } MuxSeqState_e;

   typedef struct packed {
      logic [MUX_SEQ_SEL_WIDTH-1:0]   sel;
      logic [MUX_SEQ_DWELL_WIDTH-1:0] dwell;
   } MuxSeqEntry_s;

endpackage

// File: rtl/dfd_mux_seq_dwell_cnt.sv
// Loadable saturating down-counter with a zero flag; used for both the per-entry
// dwell time and the post-switch blanking window of the mux select sequencer.
module dfd_mux_seq_dwell_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec_en,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // A load wins over a decrement; the count holds at zero instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec_en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dfd_mux_sel_sequencer.sv
// Steps the debug bus mux select through a small table of (select, dwell) entries.
// Define DFD_MUX_SEQ_TICK_SYNC_EN to align every entry load to time_tick.
module dfd_mux_sel_sequencer
   import dfd_tt_dbm_pkg::*;
#(
   parameter int NUM_ENTRIES  = 4,
   parameter int SEL_WIDTH    = MUX_SEQ_SEL_WIDTH,
   parameter int DWELL_WIDTH  = MUX_SEQ_DWELL_WIDTH,
   parameter int BLANK_CYCLES = DBG_MUX_PIPE_DEPTH,
   localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_wr_en,
   input  logic [IDX_WIDTH-1:0]   cfg_wr_idx,
   input  logic [SEL_WIDTH-1:0]   cfg_wr_sel,
   input  logic [DWELL_WIDTH-1:0] cfg_wr_dwell,
   input  logic [IDX_WIDTH-1:0]   cfg_last_idx,
   input  logic                   cfg_one_shot,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   time_tick,
   output logic [SEL_WIDTH-1:0]   mux_sel,
   output logic                   sel_valid,
   output logic [IDX_WIDTH-1:0]   cur_idx,
   output logic                   switch_pulse,
   output logic                   busy,
   output logic                   done
);

   localparam int BLANK_WIDTH = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

`ifdef DFD_MUX_SEQ_TICK_SYNC_EN
   localparam MuxSeqState_e START_STATE = MUX_SEQ_ARM;
   localparam logic         START_LOADS = 1'b0;
`else
   localparam MuxSeqState_e START_STATE = MUX_SEQ_RUN;
   localparam logic         START_LOADS = 1'b1;
`endif

   MuxSeqState_e         state;
   MuxSeqEntry_s         sel_table [NUM_ENTRIES];
   logic                 load_en;
   logic                 go_done;
   logic                 step_ok;
   logic [IDX_WIDTH-1:0] load_idx;
   logic                 dwell_zero;
   logic                 blank_zero;

   // Table storage is the package entry layout; narrower ports are zero-extended into it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_table[i] <= '0;
         end
      end else if (cfg_wr_en) begin
         sel_table[cfg_wr_idx].sel   <= MUX_SEQ_SEL_WIDTH'(cfg_wr_sel);
         sel_table[cfg_wr_idx].dwell <= MUX_SEQ_DWELL_WIDTH'(cfg_wr_dwell);
      end
   end

`ifdef DFD_MUX_SEQ_TICK_SYNC_EN
   // A zero dwell counter without a tick is the hold sub-state of RUN.
   assign step_ok = time_tick;
`else
   logic unused_time_tick;
   assign unused_time_tick = time_tick;
   assign step_ok          = 1'b1;
`endif

   // Decide whether this edge loads an entry (and which) or finishes a one-shot pass.
   always_comb begin
      load_en  = 1'b0;
      go_done  = 1'b0;
      load_idx = '0;
      case (state)
         MUX_SEQ_RUN: begin
            if (dwell_zero && step_ok) begin
               if (cur_idx == cfg_last_idx) begin
                  if (cfg_one_shot) begin
                     go_done = 1'b1;
                  end else begin
                     load_en = 1'b1;
                  end
               end else begin
                  load_en  = 1'b1;
                  load_idx = cur_idx + IDX_WIDTH'(1);
               end
            end
         end
`ifdef DFD_MUX_SEQ_TICK_SYNC_EN
         MUX_SEQ_ARM: begin
            load_en = time_tick;
         end
`endif
         default: begin
         end
      endcase
      if (start) begin
         load_en  = START_LOADS;
         go_done  = 1'b0;
         load_idx = '0;
      end
      if (stop) begin
         load_en = 1'b0;
         go_done = 1'b0;
      end
   end

   // Sequencer state and registered outputs; stop outranks start, start outranks stepping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= MUX_SEQ_IDLE;
         mux_sel      <= '0;
         cur_idx      <= '0;
         switch_pulse <= 1'b0;
         done         <= 1'b0;
      end else begin
         switch_pulse <= load_en;
         if (load_en) begin
            mux_sel <= SEL_WIDTH'(sel_table[load_idx].sel);
            cur_idx <= load_idx;
         end
         if (stop) begin
            state <= MUX_SEQ_IDLE;
         end else if (start) begin
            state <= START_STATE;
            done  <= 1'b0;
         end else if (go_done) begin
            state <= MUX_SEQ_DONE;
            done  <= 1'b1;
         end else if (load_en) begin
            state <= MUX_SEQ_RUN;
         end
      end
   end

   dfd_mux_seq_dwell_cnt #(.WIDTH(DWELL_WIDTH)) u_dwell_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load_en),
      .load_val (DWELL_WIDTH'(sel_table[load_idx].dwell)),
      .dec_en   (state == MUX_SEQ_RUN),
      .zero     (dwell_zero)
   );

   dfd_mux_seq_dwell_cnt #(.WIDTH(BLANK_WIDTH)) u_blank_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load_en),
      .load_val (BLANK_WIDTH'(BLANK_CYCLES)),
      .dec_en   (1'b1),
      .zero     (blank_zero)
   );

   assign sel_valid = ((state == MUX_SEQ_RUN) || (state == MUX_SEQ_DONE)) && blank_zero;
   assign busy      = (state != MUX_SEQ_IDLE);

endmodule
